// File: rtl/msx_bus_host.sv
// msx_bus_host: MSX cartridge-slot bus master.
// Accepts one command (MEMRD/MEMWR/IORD/IOWR) at a time, runs a SETUP / STROBE / [WAIT] / HOLD
// sequence on the cartridge bus, and returns a one-cycle response pulse with read data.
//
// Ports:
//   RESET_n, CLK                 async active-low reset, clock
//   CMD_VALID/CMD_READY          command handshake; CMD_TYPE 0=MEMRD 1=MEMWR 2=IORD 3=IOWR
//   CMD_ADDR, CMD_WDATA          command address / write data
//   RSP_VALID, RSP_RDATA, RSP_ERR  one-cycle response, read data (held), timeout flag (held)
//   BUS_*                        registered cartridge bus outputs; BUS_DIN / BUS_WAIT_n inputs
//
// Optional feature: define MSX_BUS_HOST_WAIT_TIMEOUT_EN to bound WAIT at TIMEOUT_CYCLES and
// report RSP_ERR. Without it WAIT is unbounded and RSP_ERR is constant 0.
module msx_bus_host #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        RESET_n,
  input  logic        CLK,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [15:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_DOE,
  input  logic [7:0]  BUS_DIN,
  output logic        BUS_SLTSL_n,
  output logic        BUS_MERQ_n,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  input  logic        BUS_WAIT_n
);

  // Zero-valued phase lengths behave as one cycle.
  localparam int unsigned SetupN   = (SETUP_CYCLES   == 0) ? 1 : SETUP_CYCLES;
  localparam int unsigned StrobeN  = (STROBE_CYCLES  == 0) ? 1 : STROBE_CYCLES;
  localparam int unsigned HoldN    = (HOLD_CYCLES    == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned TimeoutN = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;

  localparam int unsigned Max2 = (SetupN > StrobeN) ? SetupN : StrobeN;
  localparam int unsigned Max3 = (Max2 > HoldN) ? Max2 : HoldN;
  localparam int unsigned MaxN = (Max3 > TimeoutN) ? Max3 : TimeoutN;
  localparam int unsigned CntW = $clog2(MaxN) + 1;

  localparam logic [CntW-1:0] SetupLast  = CntW'(SetupN - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(StrobeN - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HoldN - 1);
`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
  localparam logic [CntW-1:0] WaitLast   = CntW'(TimeoutN - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StHold,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0]  cmd_type_q, cmd_type_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_wdata_q, cmd_wdata_d;

  logic       wait_s1_q, wait_s2_q;

  logic       ready_q, ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rdata_q, rdata_d;

  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        sltsl_n_q, sltsl_n_d;
  logic        merq_n_q, merq_n_d;
  logic        iorq_n_q, iorq_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;

`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
  logic to_q, to_d;
  logic err_q, err_d;
`endif

  logic cmd_is_io, cmd_is_rd, active, strobing;

  // WAIT_n is asynchronous to CLK; idle value is "not waiting".
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wait_s1_q <= 1'b1;
      wait_s2_q <= 1'b1;
    end else begin
      wait_s1_q <= BUS_WAIT_n;
      wait_s2_q <= wait_s1_q;
    end
  end

  // Next-state, phase counter and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_type_d  = cmd_type_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
    to_d        = to_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (CMD_VALID && ready_q) begin
          cmd_type_d  = CMD_TYPE;
          cmd_addr_d  = CMD_ADDR;
          cmd_wdata_d = CMD_WDATA;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          cnt_d = '0;
          if (!wait_s2_q) begin
            state_d = StWait;
          end else begin
            state_d = StHold;
            if (!cmd_type_q[0]) rdata_d = BUS_DIN;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        if (wait_s2_q) begin
          cnt_d   = '0;
          state_d = StHold;
          if (!cmd_type_q[0]) rdata_d = BUS_DIN;
`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
        end else if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StHold;
          rdata_d = 8'hFF;
          to_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StResp;
`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
          // Error flag becomes visible together with RSP_VALID.
          err_d   = to_q;
          to_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Bus outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    cmd_is_io = cmd_type_d[1];
    cmd_is_rd = ~cmd_type_d[0];
    active    = (state_d == StSetup) || (state_d == StStrobe) ||
                (state_d == StWait)  || (state_d == StHold);
    strobing  = (state_d == StStrobe) || (state_d == StWait);

    ready_d     = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);

    addr_d    = active ? cmd_addr_d : addr_q;
    dout_d    = (active && !cmd_is_rd) ? cmd_wdata_d : dout_q;
    doe_d     = active && !cmd_is_rd;
    sltsl_n_d = ~(active && !cmd_is_io);
    merq_n_d  = ~(active && !cmd_is_io);
    iorq_n_d  = ~(active && cmd_is_io);
    rd_n_d    = ~(strobing && cmd_is_rd);
    wr_n_d    = ~(strobing && !cmd_is_rd);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_type_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'hFF;
      addr_q      <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      sltsl_n_q   <= 1'b1;
      merq_n_q    <= 1'b1;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      sltsl_n_q   <= sltsl_n_d;
      merq_n_q    <= merq_n_d;
      iorq_n_q    <= iorq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign RSP_ERR = err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign CMD_READY   = ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rdata_q;
  assign BUS_ADDR    = addr_q;
  assign BUS_DOUT    = dout_q;
  assign BUS_DOE     = doe_q;
  assign BUS_SLTSL_n = sltsl_n_q;
  assign BUS_MERQ_n  = merq_n_q;
  assign BUS_IORQ_n  = iorq_n_q;
  assign BUS_RD_n    = rd_n_q;
  assign BUS_WR_n    = wr_n_q;

endmodule

// File: tb/tb_msx_bus_host.sv
// Directed bench for msx_bus_host. Inputs are driven and outputs sampled on the falling edge.
// Cycle c=1 is the first cycle after the accepting clock edge.
module tb_msx_bus_host;

  logic        RESET_n, CLK;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [15:0] CMD_ADDR;
  logic [7:0]  CMD_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [7:0]  RSP_RDATA;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DOUT, BUS_DIN;
  logic        BUS_DOE, BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_WAIT_n;

  msx_bus_host #(
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (4),
    .HOLD_CYCLES   (2),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .RESET_n    (RESET_n),
    .CLK        (CLK),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_DOUT   (BUS_DOUT),
    .BUS_DOE    (BUS_DOE),
    .BUS_DIN    (BUS_DIN),
    .BUS_SLTSL_n(BUS_SLTSL_n),
    .BUS_MERQ_n (BUS_MERQ_n),
    .BUS_IORQ_n (BUS_IORQ_n),
    .BUS_RD_n   (BUS_RD_n),
    .BUS_WR_n   (BUS_WR_n),
    .BUS_WAIT_n (BUS_WAIT_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request/strobe exclusivity watched on every cycle.
  always @(negedge CLK) begin
    if (!BUS_MERQ_n && !BUS_IORQ_n) overlap++;
    if (!BUS_RD_n && !BUS_WR_n) overlap++;
  end

  int lat, merq_lo, iorq_lo, slt_lo, rd_lo, wr_lo, doe_hi, dout_ok, addr_ok;

  // Issue one command and tally bus activity until RSP_VALID (lat=0 if it never comes).
  // wait_rel>0 holds WAIT_n low from c=1 up to (not including) c=wait_rel, where BUS_DIN
  // also switches to din_after.
  task automatic run_cmd(input logic [1:0] typ, input logic [15:0] addr, input logic [7:0] wd,
                         input int wait_rel, input logic [7:0] din_after, input int max_cyc);
    int guard;
    CMD_TYPE  = typ;
    CMD_ADDR  = addr;
    CMD_WDATA = wd;
    CMD_VALID = 1'b1;
    guard = 0;
    while (!CMD_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    lat = 0; merq_lo = 0; iorq_lo = 0; slt_lo = 0; rd_lo = 0; wr_lo = 0;
    doe_hi = 0; dout_ok = 0; addr_ok = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (wait_rel > 0 && c == 1) BUS_WAIT_n = 1'b0;
      if (c == wait_rel) begin
        BUS_WAIT_n = 1'b1;
        BUS_DIN    = din_after;
      end
      if (!BUS_MERQ_n) merq_lo++;
      if (!BUS_IORQ_n) iorq_lo++;
      if (!BUS_SLTSL_n) slt_lo++;
      if (!BUS_RD_n) rd_lo++;
      if (!BUS_WR_n) wr_lo++;
      if (BUS_DOE) begin
        doe_hi++;
        if (BUS_DOUT == wd) dout_ok++;
      end
      if ((!BUS_MERQ_n || !BUS_IORQ_n) && BUS_ADDR == addr) addr_ok++;
      if (RSP_VALID) begin
        lat = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  int hs, rsp, gap_min, idle_run, seen_act, bad;
  logic hs_now, act;

  initial begin
    RESET_n = 1'b0; CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_WDATA = '0;
    BUS_DIN = 8'h00; BUS_WAIT_n = 1'b1;

    // Reset state.
    #12;
    check("reset_bus", {BUS_ADDR, BUS_DOUT, BUS_DOE, BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n,
                        BUS_RD_n, BUS_WR_n}, {16'h0, 8'h0, 1'b0, 5'b11111});
    check("reset_rsp", {CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR}, {1'b0, 1'b0, 8'hFF, 1'b0});
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", CMD_READY, 1);

    // MEMRD, no wait.
    BUS_DIN = 8'hA5;
    run_cmd(2'd0, 16'h4000, 8'h00, 0, 8'h00, 40);
    check("memrd_lat", lat, 9);
    check("memrd_merq", merq_lo, 8);
    check("memrd_sltsl", slt_lo, 8);
    check("memrd_iorq", iorq_lo, 0);
    check("memrd_rd", rd_lo, 4);
    check("memrd_wr", wr_lo, 0);
    check("memrd_addr", addr_ok, 8);
    check("memrd_rsp", {RSP_RDATA, RSP_ERR}, {8'hA5, 1'b0});

    // IOWR.
    @(negedge CLK);
    run_cmd(2'd3, 16'h0098, 8'h3C, 0, 8'h00, 40);
    check("iowr_lat", lat, 9);
    check("iowr_iorq", iorq_lo, 8);
    check("iowr_sltsl", slt_lo, 0);
    check("iowr_merq", merq_lo, 0);
    check("iowr_wr", wr_lo, 4);
    check("iowr_rd", rd_lo, 0);
    check("iowr_doe", doe_hi, 8);
    check("iowr_dout", dout_ok, 8);
    check("iowr_rdata_kept", RSP_RDATA, 8'hA5);

    // IORD.
    @(negedge CLK);
    BUS_DIN = 8'h5C;
    run_cmd(2'd2, 16'h00A8, 8'h00, 0, 8'h00, 40);
    check("iord_lat", lat, 9);
    check("iord_iorq_rd", {iorq_lo[7:0], rd_lo[7:0], slt_lo[7:0]}, {8'd8, 8'd4, 8'd0});
    check("iord_rdata", RSP_RDATA, 8'h5C);

    // MEMRD with WAIT_n low for c=1..20: WAIT until c=23, HOLD c=24..25, RESP c=26.
    @(negedge CLK);
    BUS_DIN = 8'h77;
    run_cmd(2'd0, 16'h8001, 8'h00, 21, 8'h5A, 60);
    check("wait_lat", lat, 26);
    check("wait_rd", rd_lo, 21);
    check("wait_merq", merq_lo, 25);
    check("wait_rdata", RSP_RDATA, 8'h5A);

    // WAIT_n stuck low.
    @(negedge CLK);
`ifdef MSX_BUS_HOST_WAIT_TIMEOUT_EN
    run_cmd(2'd0, 16'h4010, 8'h00, 5000, 8'h00, 100);
    check("timeout_lat", lat, 25);
    check("timeout_rsp", {RSP_RDATA, RSP_ERR}, {8'hFF, 1'b1});
    BUS_WAIT_n = 1'b1;
`else
    run_cmd(2'd0, 16'h4010, 8'h00, 5000, 8'h00, 1000);
    check("stuck_no_rsp", lat, 0);
    BUS_WAIT_n = 1'b1;
    rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (RSP_VALID) rsp++;
    end
    check("stuck_release_rsp", rsp, 1);
`endif
    // A normal read clears any earlier error.
    @(negedge CLK);
    BUS_DIN = 8'h33;
    run_cmd(2'd0, 16'h4020, 8'h00, 0, 8'h00, 40);
    check("post_rsp", {RSP_RDATA, RSP_ERR}, {8'h33, 1'b0});

    // Three commands with CMD_VALID held high.
    @(negedge CLK);
    CMD_TYPE = 2'd0; CMD_ADDR = 16'h1000; CMD_WDATA = 8'h00; CMD_VALID = 1'b1;
    hs = 0; rsp = 0; gap_min = 1000; idle_run = 0; seen_act = 0;
    for (int c = 0; c < 60; c++) begin
      act = !BUS_MERQ_n || !BUS_IORQ_n;
      if (act) begin
        if (seen_act != 0 && idle_run > 0 && idle_run < gap_min) gap_min = idle_run;
        idle_run = 0;
        seen_act = 1;
      end else if (seen_act != 0) begin
        idle_run++;
      end
      if (RSP_VALID) rsp++;
      hs_now = CMD_READY && CMD_VALID;
      @(negedge CLK);
      if (hs_now) begin
        hs++;
        if (hs == 1) begin CMD_TYPE = 2'd3; CMD_ADDR = 16'h0099; CMD_WDATA = 8'h12; end
        else if (hs == 2) begin CMD_TYPE = 2'd1; CMD_ADDR = 16'h2000; CMD_WDATA = 8'h34; end
        else CMD_VALID = 1'b0;
      end
    end
    check("b2b_handshakes", hs, 3);
    check("b2b_responses", rsp, 3);
    check("b2b_idle_gap", (gap_min >= 1 && gap_min < 1000), 1);

    // Reset pulse during STROBE of a write.
    run_cmd(2'd1, 16'h3000, 8'hC3, 0, 8'h00, 4);
    check("abort_in_strobe", BUS_WR_n, 0);
    #2;
    RESET_n = 1'b0;
    #1;
    check("abort_bus", {BUS_DOE, BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n},
          {1'b0, 5'b11111});
    check("abort_rsp", {CMD_READY, RSP_VALID}, {1'b0, 1'b0});
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    check("abort_ready", CMD_READY, 1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (RSP_VALID || !BUS_WR_n || BUS_DOE) bad++;
      @(negedge CLK);
    end
    check("abort_no_rsp", bad, 0);

    check("never_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
